mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between the instruction-fetch requester and the data requester (load/store).
//  Sits between the multicycle control unit / datapath and the memory.
//  Each access runs a fixed MEM_LAT-cycle memory timing; completion is signalled with a one-cycle done pulse.
//  A bounded-priority scheme keeps fetch from starving.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and memory
//  DATA_W      32  data width
//  MEM_LAT     2   memory read latency in cycles (>=1); mem_rdata valid at end of last ACC cycle
//  STARVE_MAX  4   consecutive data wins (with fetch pending) before fetch is forced
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  if_req       in   1       fetch request; hold until if_done
//  if_addr      in   ADDR_W  fetch address
//  if_rdata     out  DATA_W  fetched instruction; registered, updated with if_done
//  if_done      out  1       one-cycle completion pulse, fetch
//  d_req        in   1       data request; hold until d_done
//  d_we         in   1       1 = store, 0 = load
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  store data
//  d_rdata      out  DATA_W  load data; registered, updated with d_done on loads only
//  d_done       out  1       one-cycle completion pulse, data
//  mem_addr     out  ADDR_W  memory address
//  mem_wr       out  1       memory write strobe
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data
//  busy         out  1       access in progress (state != IDLE)
//  owner        out  1       current grant: 0 = fetch, 1 = data; 0 when idle
// BEHAVIOUR
//  Reset values
//   - rst low: state=IDLE and all outputs 0, immediately and asynchronously.
//   - Also cleared: if_rdata, d_rdata, streak counter, latched addr/wdata/we.
//  States and transitions
//   - IDLE: if any req is high, grant, latch owner's addr/wdata/we, load wait counter with MEM_LAT-1, go to ACC.
//   - ACC: mem_addr/mem_wdata driven from latches; counter decrements each cycle.
//     At counter==0, capture mem_rdata into the owner's rdata (loads/fetch only) and go to RESP.
//   - RESP: owner's done=1 for exactly this cycle, then IDLE. Reqs are ignored in RESP and ACC.
//  Timing (grant in IDLE = cycle 0)
//   - Cycles 1..MEM_LAT: ACC. Cycle MEM_LAT+1: RESP/done.
//   - One access per MEM_LAT+2 cycles.
//   - mem_wr is high only in the first ACC cycle of a store.
//   - mem_addr=0 in IDLE and RESP.
//  Arbitration (IDLE only)
//   - Single requester is always granted.
//   - Both requesting: data wins, unless streak==STARVE_MAX, then fetch wins.
//   - Streak: +1 on a data grant while if_req is high; cleared on any fetch grant; saturates at STARVE_MAX.
//  Boundary conditions
//   - req dropped mid-access: access still completes and done still pulses.
//   - Inputs changing mid-access: no effect, because they are latched at grant.
//   - req still high in the IDLE cycle after done: treated as a new request.
//   - Reset mid-access: access abandoned, no done; mem_wr drops at once.
//   - Counter width is $clog2(MEM_LAT+1); MEM_LAT=1 gives one ACC cycle.
// TESTING
//  1. Fetch only, MEM_LAT=2, if_addr=0x100, mem returns 0x00500093 -> if_done at cycle 3, if_rdata=0x00500093, mem_wr never 1.
//  2. Store, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_wr=1 only in cycle 1 with mem_addr=0x20; d_done at cycle 3; d_rdata unchanged.
//  3. if_req and d_req both high at cycle 0 -> d_done at cycle 3, fetch granted cycle 4, if_done at cycle 7, owner 1 then 0.
//  4. if_req and d_req held high continuously, STARVE_MAX=4 -> 4 data grants, 5th grant to fetch, then data again.
//  5. rst low during ACC of a store -> mem_wr, busy, done all 0 immediately; after release, IDLE with no spurious done.
//  6. MEM_LAT=1 build, load from 0x40 returning 0x1234 -> d_done at cycle 2, d_rdata=0x1234.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester, memory port and status
// signals that connect to mem_port_arbiter.
// slave  : the arbiter's view (requests and memory read data come in).
// master : the surrounding system's view (requesters, memory, observers).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    // memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // status
    logic              busy;
    logic              owner;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Every access takes a fixed MEM_LAT cycles in ACC followed by one RESP
// cycle carrying the owner's done pulse. Data normally wins a tie, but after
// STARVE_MAX consecutive data wins with fetch waiting, fetch is forced.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,   // asynchronous, active-low
    mem_port_arbiter_if.slave     bus
);

    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam int STRK_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                owner_q,    owner_d;     // 0 = fetch, 1 = data
    logic                we_q,       we_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [STRK_W-1:0]   streak_q,   streak_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;

    logic                grant_data;

    // Fetch is forced only when it is waiting and data has already won
    // STARVE_MAX times in a row.
    always_comb begin
        grant_data = bus.d_req && !(bus.if_req && (streak_q == STRK_MAX));
    end

    // Next-state, latch capture, wait counter and streak bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ST_ACC;
                    cnt_d   = CNT_INIT;
                    owner_d = grant_data;
                    if (grant_data) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        we_d    = bus.d_we;
                        // Only wins against a waiting fetch count; a forced
                        // fetch grant happens before the counter can pass MAX.
                        if (bus.if_req && (streak_q != STRK_MAX)) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                        we_d     = 1'b0;
                        streak_d = '0;
                    end
                end
            end

            ST_ACC: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Outputs decode from the state register so a reset clears them at once.
    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.owner     = (state_q != ST_IDLE) && owner_q;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wr    = 1'b0;
        bus.if_done   = 1'b0;
        bus.d_done    = 1'b0;
        bus.if_rdata  = if_rdata_q;
        bus.d_rdata   = d_rdata_q;

        if (state_q == ST_ACC) begin
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
            // The counter still holds its load value in the first ACC cycle.
            bus.mem_wr    = we_q && (cnt_q == CNT_INIT);
        end

        if (state_q == ST_RESP) begin
            bus.if_done = !owner_q;
            bus.d_done  = owner_q;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-timeline model checks
// the MEM_LAT=2 instance every cycle; literal checks pin the key timings.
module tb_mem_port_arbiter;

    localparam int L    = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // memory: word array, stores land on the clock edge
    logic [31:0] arr [256];
    bit          arr_ready = 1'b0;

    assign bus.mem_rdata  = arr[bus.mem_addr[9:2]];
    assign bus1.mem_rdata = arr[bus1.mem_addr[9:2]];

    always @(posedge clk) begin
        if (!arr_ready) begin
            for (int i = 0; i < 256; i++) arr[i] <= 32'hA5A5_0000 | 32'(i);
            arr[64]   <= 32'h0050_0093;   // 0x100
            arr[16]   <= 32'h0000_1234;   // 0x40
            arr_ready <= 1'b1;
        end else if (bus.mem_wr) begin
            arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    int          cyc      = 0;
    bit          m_busy   = 1'b0;
    bit          m_own    = 1'b0;
    int          m_start  = 0;
    bit          m_we     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_ifr    = '0;
    logic [31:0] m_dr     = '0;
    int          m_streak = 0;

    always @(negedge clk) begin
        int  ph;
        bit  in_acc;
        bit  take_data;
        if (!rst) begin
            chk($sformatf("c%0d rst busy", cyc),   bus.busy,    0);
            chk($sformatf("c%0d rst mem_wr", cyc), bus.mem_wr,  0);
            chk($sformatf("c%0d rst done", cyc),   {bus.if_done, bus.d_done}, 0);
            chk($sformatf("c%0d rst addr", cyc),   bus.mem_addr, 0);
            m_busy = 0; m_streak = 0; m_ifr = '0; m_dr = '0;
        end else begin
            ph     = m_busy ? (cyc - m_start) : 0;
            in_acc = m_busy && (ph >= 1) && (ph <= L);
            chk($sformatf("c%0d busy", cyc),     bus.busy,     32'(m_busy));
            chk($sformatf("c%0d owner", cyc),    bus.owner,    32'(m_busy && m_own));
            chk($sformatf("c%0d mem_addr", cyc), bus.mem_addr, in_acc ? m_addr : 32'h0);
            chk($sformatf("c%0d mem_wr", cyc),   bus.mem_wr,   32'(m_busy && ph == 1 && m_we));
            if (in_acc && m_we)
                chk($sformatf("c%0d mem_wdata", cyc), bus.mem_wdata, m_wdata);
            chk($sformatf("c%0d if_done", cyc),  bus.if_done,  32'(m_busy && ph == L + 1 && !m_own));
            chk($sformatf("c%0d d_done", cyc),   bus.d_done,   32'(m_busy && ph == L + 1 && m_own));
            chk($sformatf("c%0d if_rdata", cyc), bus.if_rdata, m_ifr);
            chk($sformatf("c%0d d_rdata", cyc),  bus.d_rdata,  m_dr);

            if (m_busy && ph == L && !m_we) begin
                if (m_own) m_dr  = arr[m_addr[9:2]];
                else       m_ifr = arr[m_addr[9:2]];
            end

            if (m_busy && ph == L + 1) begin
                m_busy = 0;
            end else if (!m_busy && (bus.if_req || bus.d_req)) begin
                take_data = bus.d_req && !(bus.if_req && m_streak >= SMAX);
                m_busy  = 1;
                m_start = cyc;
                m_own   = take_data;
                if (take_data) begin
                    m_addr  = bus.d_addr;
                    m_wdata = bus.d_wdata;
                    m_we    = bus.d_we;
                    if (bus.if_req) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
                end else begin
                    m_addr   = bus.if_addr;
                    m_we     = 0;
                    m_streak = 0;
                end
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit is_data, input int n0, output int n);
        n = n0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (is_data ? bus.d_done : bus.if_done) return;
        end
        n = -1;
    endtask

    task automatic wait_any(output int n, output bit who);
        n = 0;
        who = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (bus.d_done || bus.if_done) begin
                who = bus.d_done;
                return;
            end
        end
        n = -1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int          n, n2;
        bit          who;
        logic [5:0]  seq;

        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0;
        bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset busy",     bus.busy,     0);
        chk("reset owner",    bus.owner,    0);
        chk("reset mem_wr",   bus.mem_wr,   0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset if_rdata", bus.if_rdata, 0);
        chk("reset d_rdata",  bus.d_rdata,  0);
        chk("reset done",     {bus.if_done, bus.d_done}, 0);
        repeat (3) tick();
        rst = 1'b1;

        // 1: fetch only
        tick();
        bus.if_addr = 32'h100; bus.if_req = 1;
        wait_done(0, 0, n);
        chk("t1 if_done cycle", n, 3);
        chk("t1 if_rdata", bus.if_rdata, 32'h0050_0093);
        chk("t1 owner", bus.owner, 0);
        bus.if_req = 0;

        // 2: store
        tick();
        bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF; bus.d_req = 1;
        tick();
        chk("t2 mem_wr c1", bus.mem_wr, 1);
        chk("t2 mem_addr c1", bus.mem_addr, 32'h20);
        chk("t2 mem_wdata c1", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t2 mem_wr c2", bus.mem_wr, 0);
        wait_done(1, 2, n);
        chk("t2 d_done cycle", n, 3);
        chk("t2 d_rdata kept", bus.d_rdata, 0);
        bus.d_req = 0; bus.d_we = 0;

        // 3: simultaneous requests, data first then fetch
        tick();
        bus.if_addr = 32'h100; bus.d_addr = 32'h40; bus.if_req = 1; bus.d_req = 1;
        wait_done(1, 0, n);
        chk("t3 d_done cycle", n, 3);
        chk("t3 owner data", bus.owner, 1);
        chk("t3 d_rdata", bus.d_rdata, 32'h1234);
        bus.d_req = 0;
        wait_done(0, n, n2);
        chk("t3 if_done cycle", n2, 7);
        chk("t3 owner fetch", bus.owner, 0);
        bus.if_req = 0;

        // 4: both held: four data grants, forced fetch, data again
        tick();
        bus.if_addr = 32'h104; bus.d_addr = 32'h40; bus.if_req = 1; bus.d_req = 1;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            wait_any(n, who);
            if (n < 0) chk($sformatf("t4 wait %0d", i), 32'(n), 4);
            seq[i] = who;
        end
        chk("t4 grant order", 32'(seq), 32'b10_1111);
        chk("t4 if_rdata", bus.if_rdata, 32'hA5A5_0041);
        bus.if_req = 0; bus.d_req = 0;

        // 5: reset during a store's ACC
        tick();
        bus.d_we = 1; bus.d_addr = 32'h30; bus.d_wdata = 32'h1111_2222; bus.d_req = 1;
        tick();
        chk("t5 mem_wr before rst", bus.mem_wr, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5 mem_wr", bus.mem_wr, 0);
        chk("t5 busy", bus.busy, 0);
        chk("t5 done", {bus.if_done, bus.d_done}, 0);
        chk("t5 d_rdata cleared", bus.d_rdata, 0);
        bus.d_req = 0; bus.d_we = 0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5 post %0d", i), {bus.busy, bus.if_done, bus.d_done}, 0);
        end
        chk("t5 no write", arr[12], 32'hA5A5_000C);

        // 7: load whose request and inputs change mid-access
        tick();
        bus.d_we = 0; bus.d_addr = 32'h20; bus.d_req = 1;
        tick();
        bus.d_req = 0; bus.d_addr = 32'h44; bus.d_we = 1; bus.d_wdata = '0;
        wait_done(1, 1, n);
        chk("t7 d_done cycle", n, 3);
        chk("t7 d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_we = 0;

        // 6: MEM_LAT=1 instance
        tick();
        bus1.d_we = 0; bus1.d_addr = 32'h40; bus1.d_req = 1;
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                chk("t6 busy c1", bus1.busy, 1);
                chk("t6 mem_addr c1", bus1.mem_addr, 32'h40);
            end
            if (bus1.d_done) begin
                n = k;
                break;
            end
        end
        chk("t6 d_done cycle", n, 2);
        chk("t6 d_rdata", bus1.d_rdata, 32'h1234);
        bus1.d_req = 0;

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
